// File: rtl/mod_counter_bus_pkg.sv
// Shared types and constants for the bus-loadable modulo counter.
package mod_counter_pkg;

  typedef enum logic [1:0] {
    SEQ_DRIVE   = 2'd0,
    SEQ_RELEASE = 2'd1,
    SEQ_CAPTURE = 2'd2
  } seq_t;

  localparam int unsigned SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/mod_counter_bus_if.sv
// Shared tri-state bus split into input, output and per-bit enable paths.
interface mod_counter_bus_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] bus_in;
  logic [WIDTH-1:0] bus_out;
  logic [WIDTH-1:0] bus_oe;

  modport master (
    input  bus_in,
    output bus_out,
    output bus_oe
  );

  modport slave (
    output bus_in,
    input  bus_out,
    input  bus_oe
  );

endinterface

// File: rtl/mod_counter_bus_ctrl_sync.sv
// N-bit multi-flop synchroniser for pad-level controls; rise_o flags a rising edge on bit 0.
module ctrl_sync #(
  parameter int unsigned N      = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o,
  output logic         rise_o
);

  logic [N-1:0] sync_q [STAGES];
  logic [N-1:0] sync_d [STAGES];
  logic         prev_q;
  logic         prev_d;

  always_comb begin
    sync_d[0] = d_i;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[STAGES-1][0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1][0] & ~prev_q;

endmodule

// File: rtl/mod_counter_bus.sv
// Up/down modulo counter with synchronised pad controls and a release/capture bus load.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module mod_counter_bus
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MOD_VALUE   = 256,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PRESCALE    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_in,
  input  logic                    dir_in,
  input  logic                    load_in,
  input  logic                    oe_in,
  mod_counter_bus_if.master       bus,
  output logic [WIDTH-1:0]        count,
  output logic                    tc_pulse,
  output logic                    busy
);

  localparam int unsigned SyncDepth =
      (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD_VALUE - 1);

  logic [3:0] ctrl_s;
  logic       en_s;
  logic       dir_s;
  logic       oe_s;
  logic       load_pulse;

  // Bit 0 carries load so the synchroniser's edge detector sees it.
  ctrl_sync #(
    .N      (4),
    .STAGES (SyncDepth)
  ) u_ctrl_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    ({oe_in, en_in, dir_in, load_in}),
    .q_o    (ctrl_s),
    .rise_o (load_pulse)
  );

  assign oe_s  = ctrl_s[3];
  assign en_s  = ctrl_s[2];
  assign dir_s = ctrl_s[1];

  seq_t             seq_q, seq_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             step;

  // Load sequence: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q <= SEQ_DRIVE;
    end else begin
      seq_q <= seq_d;
    end
  end

  // Load sequence: next state. Edges arriving mid-sequence are dropped.
  always_comb begin
    seq_d = seq_q;
    unique case (seq_q)
      SEQ_DRIVE:   if (load_pulse) seq_d = SEQ_RELEASE;
      SEQ_RELEASE: seq_d = SEQ_CAPTURE;
      SEQ_CAPTURE: seq_d = SEQ_DRIVE;
      default:     seq_d = SEQ_DRIVE;
    endcase
  end

  // Load sequence: outputs, from registered state only.
  always_comb begin
    busy       = (seq_q != SEQ_DRIVE);
    bus.bus_oe = (seq_q == SEQ_DRIVE) ? {WIDTH{oe_s}} : '0;
  end

`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(PRESCALE - 1);

  logic [PsW-1:0] ps_q, ps_d;

  assign step = en_s && (ps_q == PsMax);

  always_comb begin
    ps_d = ps_q;
    if (seq_q == SEQ_CAPTURE) begin
      ps_d = '0;
    end else if (step) begin
      ps_d = '0;
    end else if (en_s) begin
      ps_d = ps_q + PsW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  assign step = en_s;
`endif

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (seq_q == SEQ_CAPTURE) begin
      count_d = (32'(bus.bus_in) >= MOD_VALUE) ? MaxVal : bus.bus_in;
    end else if (step) begin
      if (!dir_s) begin
        if (count_q == MaxVal) begin
          count_d = '0;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = MaxVal;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count       = count_q;
  assign tc_pulse    = tc_q;
  assign bus.bus_out = count_q;

endmodule

// File: tb/tb_mod_counter_bus.sv
// Directed self-checking bench for mod_counter_bus (WIDTH=8, MOD_VALUE=200).
module tb_mod_counter_bus;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_in = 1'b0;
  logic       dir_in = 1'b0;
  logic       load_in = 1'b0;
  logic       oe_in = 1'b0;
  logic [7:0] count;
  logic       tc_pulse;
  logic       busy;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned tc_seen;

  mod_counter_bus_if #(.WIDTH(8)) bus_if ();

  mod_counter_bus #(
    .WIDTH       (8),
    .MOD_VALUE   (200),
    .SYNC_STAGES (2),
    .PRESCALE    (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_in    (en_in),
    .dir_in   (dir_in),
    .load_in  (load_in),
    .oe_in    (oe_in),
    .bus      (bus_if),
    .count    (count),
    .tc_pulse (tc_pulse),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds reset two cycles; inputs set by caller beforehand. Returns on a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Load with en_s low: busy/oe low-high pattern over five cycles, then captured value.
  task automatic do_load(input logic [7:0] data, input logic [7:0] exp_cnt);
    logic inside_seq;
    bus_if.bus_in = data;
    load_in = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      inside_seq = (c == 3) || (c == 4);
      check_eq("load_busy", 32'(busy), 32'(inside_seq));
      check_eq("load_oe", 32'(bus_if.bus_oe), inside_seq ? 32'h00 : 32'hFF);
      check_eq("load_tc", 32'(tc_pulse), 32'd0);
    end
    check_eq("load_count", 32'(count), 32'(exp_cnt));
    load_in = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    int unsigned exp_c;
    logic        exp_tc;

    // 1: reset values, then count up through the wrap.
    en_in = 1'b1; dir_in = 1'b0; oe_in = 1'b1; bus_if.bus_in = 8'h00;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_tc", 32'(tc_pulse), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_oe", 32'(bus_if.bus_oe), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tc_seen = 0;
    for (int k = 1; k <= 205; k++) begin
      tick();
      exp_c  = (k < 3) ? 0 : (k - 2) % 200;
      exp_tc = (k >= 3) && (exp_c == 0);
      check_eq("up_count", 32'(count), exp_c);
      check_eq("up_tc", 32'(tc_pulse), 32'(exp_tc));
      if (tc_pulse) tc_seen++;
    end
    check_eq("up_tc_once", tc_seen, 32'd1);
    check_eq("bus_out", 32'(bus_if.bus_out), 32'(count === 8'd3 ? 8'd3 : 8'hxx));

    // 2: count down from 0 wraps to 199.
    en_in = 1'b1; dir_in = 1'b1; oe_in = 1'b0;
    do_reset();
    repeat (2) tick();
    check_eq("dn_hold", 32'(count), 32'd0);
    tick();
    check_eq("dn_wrap", 32'(count), 32'd199);
    check_eq("dn_wrap_tc", 32'(tc_pulse), 32'd1);
    tick();
    check_eq("dn_next", 32'(count), 32'd198);
    check_eq("dn_next_tc", 32'(tc_pulse), 32'd0);

    // 3/4: loads with oe requested, counting disabled.
    en_in = 1'b0; dir_in = 1'b0; oe_in = 1'b1;
    do_reset();
    repeat (3) tick();
    check_eq("oe_on", 32'(bus_if.bus_oe), 32'hFF);
    do_load(8'h2A, 8'd42);
    do_load(8'hF0, 8'd199);

    // 5: second edge lands while the sequence is busy and is dropped.
    bus_if.bus_in = 8'h10;
    load_in = 1'b1;
    tick();
    load_in = 1'b0;
    tick();
    load_in = 1'b1;
    for (int c = 3; c <= 8; c++) begin
      tick();
      check_eq("dbl_busy", 32'(busy), 32'((c == 3) || (c == 4)));
      if (c == 5) bus_if.bus_in = 8'h33;
    end
    check_eq("dbl_count", 32'(count), 32'h10);
    load_in = 1'b0;
    repeat (2) tick();

    // Reset mid-RELEASE abandons the capture at once.
    do_load(8'h2A, 8'd42);
    load_in = 1'b1;
    repeat (3) tick();
    check_eq("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_count", 32'(count), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_oe", 32'(bus_if.bus_oe), 32'h00);
    load_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef COUNTER_PRESCALE_EN
    // 6: prescaler divides steps by four.
    en_in = 1'b1; dir_in = 1'b0; oe_in = 1'b0;
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 5)  check_eq("ps_k5", 32'(count), 32'd0);
      if (k == 6)  check_eq("ps_k6", 32'(count), 32'd1);
      if (k == 17) check_eq("ps_k17", 32'(count), 32'd3);
      if (k == 18) check_eq("ps_k18", 32'(count), 32'd4);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
